// File: rtl/ahbl_dma_master.sv
// Single-channel word-copy DMA engine acting as an AHB-Lite master.
// Each word is one read (address + data phase) followed by one write.
module ahbl_dma_master #(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             START,
  input  logic [31:0]      SRC_ADDR,
  input  logic [31:0]      DST_ADDR,
  input  logic [LEN_W-1:0] LEN,
  output logic             BUSY,
  output logic             DONE,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic [31:0]      HRDATA
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [1:0]       TR_IDLE   = 2'b00;
  localparam logic [1:0]       TR_NONSEQ = 2'b10;
  localparam logic [LEN_W-1:0] CNT_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      WORD_STEP = 32'd4;

  state_t           state_r;
  logic [31:0]      src_r;
  logic [31:0]      dst_r;
  logic [LEN_W-1:0] cnt_r;
  logic [31:0]      buf_r;
  logic [31:0]      haddr_r;
  logic [1:0]       htrans_r;
  logic             hwrite_r;
  logic             busy_r;
  logic             done_r;
  logic             unused_addr_lsbs_s;

  // Byte-offset bits of the start addresses are deliberately dropped.
  assign unused_addr_lsbs_s = ^{SRC_ADDR[1:0], DST_ADDR[1:0]};

  assign HADDR  = haddr_r;
  assign HTRANS = htrans_r;
  assign HSIZE  = 3'b010;
  assign HWRITE = hwrite_r;
  assign HWDATA = buf_r;
  assign BUSY   = busy_r;
  assign DONE   = done_r;

  // Copy sequencer; bus outputs are set on the edge that enters each state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r  <= ST_IDLE;
      src_r    <= 32'd0;
      dst_r    <= 32'd0;
      cnt_r    <= CNT_ZERO;
      buf_r    <= 32'd0;
      haddr_r  <= 32'd0;
      htrans_r <= TR_IDLE;
      hwrite_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            busy_r <= 1'b1;
            if (LEN != CNT_ZERO) begin
              src_r    <= {SRC_ADDR[31:2], 2'b00};
              dst_r    <= {DST_ADDR[31:2], 2'b00};
              cnt_r    <= LEN;
              haddr_r  <= {SRC_ADDR[31:2], 2'b00};
              htrans_r <= TR_NONSEQ;
              hwrite_r <= 1'b0;
              state_r  <= ST_RD_A;
            end else begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end
        end
        ST_RD_A: begin
          if (HREADY) begin
            htrans_r <= TR_IDLE;
            state_r  <= ST_RD_D;
          end
        end
        ST_RD_D: begin
          if (HREADY) begin
            buf_r    <= HRDATA;
            haddr_r  <= dst_r;
            htrans_r <= TR_NONSEQ;
            hwrite_r <= 1'b1;
            state_r  <= ST_WR_A;
          end
        end
        ST_WR_A: begin
          if (HREADY) begin
            htrans_r <= TR_IDLE;
            hwrite_r <= 1'b0;
            state_r  <= ST_WR_D;
          end
        end
        ST_WR_D: begin
          if (HREADY) begin
            src_r <= src_r + WORD_STEP;
            dst_r <= dst_r + WORD_STEP;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              haddr_r  <= src_r + WORD_STEP;
              htrans_r <= TR_NONSEQ;
              state_r  <= ST_RD_A;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          htrans_r <= TR_IDLE;
          hwrite_r <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_dma_master.sv
// Scoreboard bench for ahbl_dma_master: a bus slave/monitor process checks
// every read address, write address/data and DONE pulse against queued expectations.
module tb_ahbl_dma_master;
  localparam int LEN_W = 16;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic             HCLK;
  logic             HRESETn;
  logic             START;
  logic [31:0]      SRC_ADDR;
  logic [31:0]      DST_ADDR;
  logic [LEN_W-1:0] LEN;
  logic             BUSY;
  logic             DONE;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [2:0]       HSIZE;
  logic             HWRITE;
  logic [31:0]      HWDATA;
  logic             HREADY;
  logic [31:0]      HRDATA;

  ahbl_dma_master #(.LEN_W(LEN_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .START(START),
    .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_rd_q[$];
  wr_t         exp_wr_q[$];
  int          exp_done_q[$];
  logic [31:0] mem [logic [31:0]];

  // slave state
  int          ws = 0;
  int          aws = 0;
  int          wait_left = 0;
  int          astall_left = 0;
  bit          dp_valid = 1'b0;
  bit          dp_write = 1'b0;
  logic [31:0] dp_addr = 32'd0;
  bit          prev_acc = 1'b0;
  bit          stall_seen = 1'b0;
  logic [31:0] st_addr;
  logic [1:0]  st_trans;
  logic        st_write;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h1234};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pattern(a);
  endfunction

  // Bus slave and monitor: decides HREADY for the next edge, then accounts for that edge.
  initial begin
    HREADY = 1'b1;
    HRDATA = 32'd0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_valid = 1'b0;
        stall_seen = 1'b0;
        prev_acc = 1'b0;
        HREADY = 1'b1;
      end else begin
        if (stall_seen) begin
          check("addr_hold_haddr", HADDR, st_addr);
          check("addr_hold_htrans", {30'd0, HTRANS}, {30'd0, st_trans});
          check("addr_hold_hwrite", {31'd0, HWRITE}, {31'd0, st_write});
          stall_seen = 1'b0;
        end
        if (dp_valid) HREADY = (wait_left == 0);
        else if (HTRANS == NONSEQ && astall_left > 0) begin
          HREADY = 1'b0;
          astall_left--;
        end else HREADY = 1'b1;
        HRDATA = (dp_valid && !dp_write && HREADY) ? mem_rd(dp_addr) : 32'hDEAD_BEEF;
        if (HREADY) begin
          if (dp_valid && dp_write) begin
            mem[dp_addr] = HWDATA;
            if (exp_wr_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_write: got addr %h data %h expected none", dp_addr, HWDATA);
            end else begin
              wr_t e;
              e = exp_wr_q.pop_front();
              check("write_addr", dp_addr, e.addr);
              check("write_data", HWDATA, e.data);
            end
          end
          if (HTRANS == NONSEQ) begin
            check("no_back_to_back_nonseq", {31'd0, prev_acc}, 32'd0);
            check("hsize", {29'd0, HSIZE}, 32'd2);
            if (!HWRITE) begin
              if (exp_rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read: got addr %h expected none", HADDR);
              end else begin
                check("read_addr", HADDR, exp_rd_q.pop_front());
              end
            end
            dp_valid = 1'b1;
            dp_addr = HADDR;
            dp_write = HWRITE;
            wait_left = ws;
          end else begin
            dp_valid = 1'b0;
          end
          prev_acc = (HTRANS == NONSEQ);
          astall_left = aws;
        end else begin
          if (dp_valid) wait_left--;
          if (HTRANS == NONSEQ) begin
            stall_seen = 1'b1;
            st_addr = HADDR;
            st_trans = HTRANS;
            st_write = HWRITE;
          end
        end
      end
    end
  end

  // DONE monitor: every pulse must match one queued completion (and its cycle when timed).
  initial forever begin
    @(negedge HCLK);
    if (HRESETn && DONE) begin
      if (exp_done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got DONE=1 at cycle %0d expected none", cyc);
      end else begin
        int e;
        e = exp_done_q.pop_front();
        check("busy_in_done", {31'd0, BUSY}, 32'd1);
        if (e >= 0) check("done_cycle", 32'(cyc), 32'(e));
      end
    end
  end

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int w, input int a, input bit timed);
    logic [31:0] sa;
    logic [31:0] da;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    ws = w;
    aws = a;
    astall_left = a;
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(sa);
      exp_wr_q.push_back('{addr: da, data: mem_rd(sa)});
      sa = sa + 32'd4;
      da = da + 32'd4;
    end
    @(negedge HCLK);
    START = 1'b1;
    SRC_ADDR = s;
    DST_ADDR = d;
    LEN = LEN_W'(n);
    exp_done_q.push_back(timed ? cyc + 1 + 4 * n : -1);
    @(negedge HCLK);
    START = 1'b0;
    check("busy_after_start", {31'd0, BUSY}, 32'd1);
  endtask

  task automatic wait_done();
    int budget;
    budget = 500;
    while ((exp_done_q.size() != 0 || BUSY) && budget > 0) begin
      @(negedge HCLK);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no completion expected DONE within 500 cycles");
    end
    @(negedge HCLK);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("idle_busy", {31'd0, BUSY}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_htrans", {30'd0, HTRANS}, 32'd0);
    check("rst_hwrite", {31'd0, HWRITE}, 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hsize", {29'd0, HSIZE}, 32'd2);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
  endtask

  initial begin
    bit found;
    HRESETn = 1'b1;
    START = 1'b0;
    SRC_ADDR = 32'd0;
    DST_ADDR = 32'd0;
    LEN = '0;
    #2 HRESETn = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // three words, zero wait states, DONE 12 cycles after START is sampled
    start_copy(32'h2000_0000, 32'h2000_0100, 3, 0, 0, 1'b1);
    wait_done();
    check("mem_copy_w2", mem_rd(32'h2000_0108), pattern(32'h2000_0008));

    // one word with two wait cycles in every data phase and address phase
    start_copy(32'h2100_0040, 32'h2100_0200, 1, 2, 2, 1'b0);
    wait_done();

    // zero length: DONE next cycle, BUSY for one cycle, no bus transfer
    @(negedge HCLK);
    START = 1'b1;
    LEN = '0;
    exp_done_q.push_back(cyc + 1);
    @(negedge HCLK);
    START = 1'b0;
    check("len0_busy_cycle1", {31'd0, BUSY}, 32'd1);
    check("len0_done_cycle1", {31'd0, DONE}, 32'd1);
    @(negedge HCLK);
    check("len0_busy_cycle2", {31'd0, BUSY}, 32'd0);
    check("len0_done_cycle2", {31'd0, DONE}, 32'd0);

    // address wrap at the top of the 32-bit space; unaligned low bits ignored
    start_copy(32'hFFFF_FFFE, 32'h0000_1001, 2, 0, 0, 1'b1);
    wait_done();

    // START while busy is ignored
    start_copy(32'h5000_0000, 32'h5000_0400, 3, 0, 0, 1'b1);
    repeat (3) @(negedge HCLK);
    START = 1'b1;
    SRC_ADDR = 32'h6000_0000;
    DST_ADDR = 32'h6000_0800;
    LEN = LEN_W'(5);
    @(negedge HCLK);
    START = 1'b0;
    wait_done();
    repeat (4) @(negedge HCLK);

    // reset during WR_A of word 2 of a 4-word copy
    start_copy(32'h3000_0000, 32'h3000_0200, 4, 0, 0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge HCLK);
      #2;
      if (HTRANS == NONSEQ && HWRITE && HADDR == 32'h3000_0204) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_wr_a_word2: got no write NONSEQ expected HADDR 30000204");
    end
    HRESETn = 1'b0;
    #1 check_reset_outputs();
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_done_q.delete();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      check("post_rst_busy", {31'd0, BUSY}, 32'd0);
      check("post_rst_htrans", {30'd0, HTRANS}, 32'd0);
    end
    start_copy(32'h4000_0000, 32'h4000_0100, 2, 0, 0, 1'b1);
    wait_done();
    check("restart_mem", mem_rd(32'h4000_0104), pattern(32'h4000_0004));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbl_dma_master.md
AHBL_DMA_MASTER -- requirements
Module: ahbl_dma_master

Interface
- REQ-001: Parameter LEN_W, default 16: width of the word-count input and counter.
- REQ-002: HCLK  input  1  single clock; all state changes on its rising edge.
- REQ-003: HRESETn  input  1  asynchronous, active-low reset.
- REQ-004: START  input  1  one-cycle request to begin a copy; sampled only in IDLE.
- REQ-005: SRC_ADDR  input  32  byte address of the first source word; bits [1:0] ignored.
- REQ-006: DST_ADDR  input  32  byte address of the first destination word; bits [1:0] ignored.
- REQ-007: LEN  input  LEN_W  number of 32-bit words to copy.
- REQ-008: BUSY  output  1  high from the cycle after an accepted START until the DONE state is left.
- REQ-009: DONE  output  1  one-cycle pulse on copy completion.
- REQ-010: HADDR  output  32  AHB-Lite master address.
- REQ-011: HTRANS  output  2  AHB-Lite transfer type; only IDLE (2'b00) and NONSEQ (2'b10) are issued.
- REQ-012: HSIZE  output  3  fixed 3'b010 (word).
- REQ-013: HWRITE  output  1  AHB-Lite write strobe.
- REQ-014: HWDATA  output  32  write data; always equals the internal data buffer.
- REQ-015: HREADY  input  1  bus ready from the splitter.
- REQ-016: HRDATA  input  32  bus read data from the splitter.

Function
- REQ-017: The controller SHALL implement the states IDLE, RD_A, RD_D, WR_A, WR_D and DONE.
- REQ-018: In IDLE, START=1 with LEN!=0 SHALL latch src={SRC_ADDR[31:2],2'b00}, dst={DST_ADDR[31:2],2'b00} and cnt=LEN, then go to RD_A.
- REQ-019: In IDLE, START=1 with LEN=0 SHALL go directly to DONE with no bus transfer.
- REQ-020: START SHALL be ignored in every state other than IDLE, and no latched value SHALL change.
- REQ-021: RD_A SHALL drive HADDR=src, HTRANS=NONSEQ and HWRITE=0, all held stable while HREADY=0. It SHALL go to RD_D on HREADY=1.
- REQ-022: RD_D SHALL drive HTRANS=IDLE. On HREADY=1 it SHALL capture HRDATA into the buffer and go to WR_A.
- REQ-023: WR_A SHALL drive HADDR=dst, HTRANS=NONSEQ and HWRITE=1, all held stable while HREADY=0. It SHALL go to WR_D on HREADY=1.
- REQ-024: WR_D SHALL drive HTRANS=IDLE, with HWDATA equal to the buffer. On HREADY=1 it SHALL:
  - set src=src+4 and dst=dst+4, both modulo 2^32, wrapping 0xFFFF_FFFC to 0x0000_0000;
  - decrement cnt;
  - go to DONE if cnt was 1, otherwise go to RD_A.
- REQ-025: DONE SHALL assert DONE for exactly one cycle and then go to IDLE.
- REQ-026: In IDLE and DONE, HTRANS SHALL be IDLE, HWRITE 0, and HADDR held at its last driven value.
- REQ-027: A NONSEQ SHALL never be issued in two consecutive accepted address phases; each word costs at least 4 cycles.
- REQ-028: BUSY SHALL be 1 in RD_A, RD_D, WR_A, WR_D and DONE, and 0 in IDLE.

Reset
- REQ-029: Asserting HRESETn low SHALL immediately force state IDLE and the following outputs, including mid-transfer:
  - HTRANS=2'b00, HWRITE=0, HADDR=0, HSIZE=3'b010;
  - HWDATA=0 (buffer cleared);
  - BUSY=0, DONE=0;
  - src=0, dst=0, cnt=0.
- REQ-030: After reset is released, no transfer SHALL start until a new START is accepted in IDLE.

Verification
- REQ-031: SRC=0x2000_0000, DST=0x2000_0100, LEN=3, HREADY=1 always -> three read/write pairs at 0x2000_0000/0x2000_0100, 0x2000_0004/0x2000_0104 and 0x2000_0008/0x2000_0108, with data copied exactly. DONE pulses 12 cycles after the START cycle+1.
- REQ-032: LEN=1 with HREADY=0 for 2 cycles in each data phase -> HADDR/HTRANS/HWRITE are stable while waiting, RD_D captures HRDATA only when HREADY=1, and a single DONE pulse occurs.
- REQ-033: LEN=0 with START=1 -> DONE pulses on the next cycle, BUSY=1 for exactly 1 cycle, and HTRANS never equals NONSEQ.
- REQ-034: SRC=0xFFFF_FFFC, DST=0x0000_1000, LEN=2 -> the second read address is 0x0000_0000 and the second write address is 0x0000_1004.
- REQ-035: START pulsed again while BUSY, with different SRC/DST/LEN values -> the original copy completes unchanged and exactly one DONE pulse occurs.
- REQ-036: HRESETn asserted during WR_A of word 2 of a 4-word copy -> all outputs take their reset values asynchronously. After release the block stays IDLE, and a fresh START restarts the copy from the new SRC.
